// File: rtl/oled_cmd_pkg.sv
// rtl/oled_cmd_pkg.sv - SSD1306 command constants, sequencer state type and ROM helpers
package oled_cmd_pkg;

    localparam logic [7:0] OLED_DISP_OFF      = 8'hAE;
    localparam logic [7:0] OLED_CHG_PUMP      = 8'h8D;
    localparam logic [7:0] OLED_CHG_PUMP_OFF  = 8'h10;
    localparam logic [7:0] OLED_NOP           = 8'hE3;
    localparam logic [7:0] OLED_SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] OLED_COL_START     = 8'h00;
    localparam logic [7:0] OLED_COL_END       = 8'h7F;
    localparam logic [7:0] OLED_SET_PAGE_ADDR = 8'h22;
    localparam logic [7:0] OLED_PAGE_START    = 8'h00;
    localparam logic [7:0] OLED_PAGE_END      = 8'h07;

    localparam int WIN_BYTES = 6;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } qs_state_t;

    // Entries past the shutdown triple are NOPs so a larger NUM_CMDS stays harmless.
    function automatic logic [7:0] default_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return OLED_DISP_OFF;
            4'd1:    return OLED_CHG_PUMP;
            4'd2:    return OLED_CHG_PUMP_OFF;
            default: return OLED_NOP;
        endcase
    endfunction

    // Window-set commands first, then the zero fill for the whole GDDRAM.
    function automatic logic [7:0] clear_byte(input logic [10:0] n);
        case (n)
            11'd0:   return OLED_SET_COL_ADDR;
            11'd1:   return OLED_COL_START;
            11'd2:   return OLED_COL_END;
            11'd3:   return OLED_SET_PAGE_ADDR;
            11'd4:   return OLED_PAGE_START;
            11'd5:   return OLED_PAGE_END;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/qs_cycle_timer.sv
// rtl/qs_cycle_timer.sv - loadable down-counter with zero flag, shared by power-up and gap waits
module qs_cycle_timer #(
    parameter int             W           = 8,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RESET_VALUE;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/oled_quiesce_seq.sv
// rtl/oled_quiesce_seq.sv - power-up wait then SSD1306 shutdown command stream to i2c_master
// Optional GDDRAM clear after the commands: define OLED_CLEAR_EN.
module oled_quiesce_seq
    import oled_cmd_pkg::*;
#(
    parameter int PWRUP_CYCLES = 12_000_000,
    parameter int GAP_CYCLES   = 10,
    parameter int NUM_CMDS     = 3,
    parameter int CLEAR_BYTES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       i2c_busy,
    output logic       i2c_start,
    output logic       i2c_dcn,
    output logic [7:0] i2c_data,
    output logic       active,
    output logic       done,
    output logic [3:0] cmd_idx
);

    localparam int         TW       = $clog2(PWRUP_CYCLES + GAP_CYCLES + 2);
    localparam logic [3:0] LAST_IDX = 4'(NUM_CMDS - 1);

    if (NUM_CMDS < 1 || NUM_CMDS > 16) begin : g_bad_num_cmds
        $error("oled_quiesce_seq: NUM_CMDS must be in 1..16");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("oled_quiesce_seq: GAP_CYCLES must be >= 1");
    end
    if (CLEAR_BYTES < 1 || CLEAR_BYTES > 1024) begin : g_bad_clear
        $error("oled_quiesce_seq: CLEAR_BYTES must be in 1..1024");
    end

    qs_state_t  state, state_n;
    logic [3:0] idx, idx_n;
    logic       timer_load, timer_zero;
    logic [7:0] data_q;
    logic       dcn_q;
    logic [3:0] cmd_idx_q;

`ifdef OLED_CLEAR_EN
    localparam logic [10:0] CLR_LAST = 11'(WIN_BYTES + CLEAR_BYTES - 1);
    logic [10:0] clr_cnt, clr_cnt_n;
    logic        clr_phase, clr_phase_n;
`endif

    qs_cycle_timer #(
        .W          (TW),
        .RESET_VALUE(TW'(PWRUP_CYCLES))
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(TW'(GAP_CYCLES - 1)),
        .zero      (timer_zero)
    );

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        timer_load = 1'b0;
`ifdef OLED_CLEAR_EN
        clr_cnt_n   = clr_cnt;
        clr_phase_n = clr_phase;
`endif
        case (state)
            S_PWRUP: if (timer_zero) state_n = S_ISSUE;
            S_ISSUE: begin
                state_n    = S_GAP;
                timer_load = 1'b1;
            end
            S_GAP:   if (timer_zero) state_n = S_WAIT;
            S_WAIT: begin
                if (i2c_busy) begin
                    state_n    = S_GAP;
                    timer_load = 1'b1;
`ifdef OLED_CLEAR_EN
                end else if (clr_phase) begin
                    if (clr_cnt == CLR_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        clr_cnt_n = clr_cnt + 11'd1;
                        state_n   = S_CLEAR;
                    end
`endif
                end else if (idx < LAST_IDX) begin
                    idx_n   = idx + 4'd1;
                    state_n = S_ISSUE;
                end else begin
`ifdef OLED_CLEAR_EN
                    clr_phase_n = 1'b1;
                    clr_cnt_n   = '0;
                    state_n     = S_CLEAR;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef OLED_CLEAR_EN
            S_CLEAR: begin
                state_n    = S_GAP;
                timer_load = 1'b1;
            end
`endif
            S_DONE: begin
                if (trigger) begin
                    idx_n   = '0;
                    state_n = S_ISSUE;
`ifdef OLED_CLEAR_EN
                    clr_phase_n = 1'b0;
`endif
                end
            end
            default: state_n = S_PWRUP;
        endcase
    end

    // Byte registers load on entry to an issue state so they hold through the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_PWRUP;
            idx       <= '0;
            data_q    <= '0;
            dcn_q     <= 1'b0;
            cmd_idx_q <= '0;
`ifdef OLED_CLEAR_EN
            clr_cnt   <= '0;
            clr_phase <= 1'b0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
`ifdef OLED_CLEAR_EN
            clr_cnt   <= clr_cnt_n;
            clr_phase <= clr_phase_n;
            if (state_n == S_CLEAR) begin
                data_q <= clear_byte(clr_cnt_n);
                dcn_q  <= (clr_cnt_n >= 11'(WIN_BYTES));
            end
`endif
            if (state_n == S_ISSUE) begin
                data_q    <= default_rom(idx_n);
                dcn_q     <= 1'b0;
                cmd_idx_q <= idx_n;
            end
        end
    end

    assign i2c_start = (state == S_ISSUE) || (state == S_CLEAR);
    assign i2c_dcn   = dcn_q;
    assign i2c_data  = data_q;
    assign cmd_idx   = cmd_idx_q;
    assign done      = (state == S_DONE);
    assign active    = (state != S_PWRUP) && (state != S_DONE);

endmodule
